adc_moving_averager: RTL and testbench
======================================

// Module: adc_moving_averager
// PURPOSE
//  Consumes the 12-bit ADC sample stream (ADC_out + response_valid strobe) from the ADC
//  front end (real MAX10 ADC or its simulation model) and produces a boxcar moving
//  average over the last 2**LOG2_N samples to suppress LSB noise.
//  Feeds the NCO/display logic with one averaged word per accepted ADC sample.
// PARAMETERS
//  DATA_W   12  width of ADC sample and averaged output
//  LOG2_N    4  log2 of window length (N = 16 samples)
// PORTS
//  MAX10_CLK1_50       in   1       system clock, 50 MHz
//  reset               in   1       asynchronous, active-high reset
//  response_valid_in   in   1       ADC sample strobe; not assumed synchronous; >=1 clk wide
//  adc_in              in   DATA_W  ADC sample; stable >=4 clks after strobe rising edge
//  avg_out             out  DATA_W  moving average (sum of window >> LOG2_N)
//  avg_valid           out  1       one-cycle pulse when avg_out is updated
//  filled              out  1       high once N samples accepted since reset (sticky)
//  overrun             out  1       sticky: strobe edge arrived while block busy
// BEHAVIOUR
//  Reset (async, any time): avg_out=0, avg_valid=0, filled=0, overrun=0, sum=0,
//   wr_ptr=0, fill_cnt=0, all 2**LOG2_N buffer entries=0, FSM=IDLE, sync FFs=0.
//  Input sync: response_valid_in -> 2-FF synchroniser -> 3rd FF; strobe_edge = s2 & ~s3
//   (one pulse per rising edge regardless of strobe width).
//  FSM (one-hot or encoded, 4 states):
//   IDLE    : on strobe_edge -> LATCH.
//   LATCH   : sample <= adc_in; old <= buf[wr_ptr] -> ACCUM.
//   ACCUM   : sum <= sum + sample - old; buf[wr_ptr] <= sample;
//             wr_ptr <= wr_ptr+1 (wraps 2**LOG2_N-1 -> 0); fill_cnt++ saturating at N -> OUT.
//   OUT     : avg_out <= sum[DATA_W+LOG2_N-1:LOG2_N]; avg_valid=1 this cycle;
//             filled <= 1 if fill_cnt==N -> IDLE.
//  Latency: strobe_edge high in cycle k -> avg_valid high in cycle k+3, exactly 1 cycle.
//  Throughput: one sample per 4 clocks min; real ADC (25 kHz) and sim model (1 MSps)
//   both well below this.
//  Arithmetic: sum is DATA_W+LOG2_N bits unsigned; N x max sample never overflows;
//   sample - old computed at sum width (add then subtract, no intermediate wrap error).
//   Truncating divide (floor), no rounding.
//  Fill phase: buffer preloaded with zeros, so before N samples avg ramps up
//   (avg = floor(sum_of_k_samples / N)); filled marks when output is a true window avg.
//  Overrun: strobe_edge while FSM != IDLE -> edge dropped, overrun <= 1 until reset;
//   in-flight sample completes normally.
//  avg_out holds its value between avg_valid pulses.
//  Strobe held high across many clocks -> single sample only.
// TESTING
//  1 Reset, then 16 strobes with adc_in=0x100 spaced 50 clks -> avg_out 0x010,0x020,...,
//    0x100 on successive avg_valid; filled rises with the 16th avg_valid.
//  2 Continue from 1 with 8 strobes of 0x200 -> final avg_out=0x180; wr_ptr wraps, no glitch.
//  3 Sim-model stream: upper bits 0x8C0, lower 5 bits counting 0..31 -> once filled,
//    avg_out = 0x8C0 + floor(mean of last 16 counts), e.g. counts 0..15 -> 0x8C7.
//  4 16 strobes of 0xFFF -> avg_out=0xFFF, no overflow; then 16 of 0x000 -> avg_out=0x000.
//  5 Strobe edge at cycle k, second edge at k+2 -> one avg_valid at k+3, overrun=1;
//    strobe held high 100 clks -> exactly one avg_valid.
//  6 Assert reset mid-ACCUM after 5 samples -> all outputs 0 immediately; next 16
//    samples of 0x100 reproduce scenario 1 exactly (buffer cleared).

Source files
------------

// File: rtl/adc_moving_averager.sv
// Boxcar moving average over the last 2**LOG2_N ADC samples. The async strobe is
// synchronised, edge-detected, and each accepted edge runs a 4-state update sequence.
module adc_moving_averager #(
  parameter int DATA_W = 12,
  parameter int LOG2_N = 4
) (
  input  logic              MAX10_CLK1_50,
  input  logic              reset,
  input  logic              response_valid_in,
  input  logic [DATA_W-1:0] adc_in,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              filled,
  output logic              overrun
);
  localparam int N  = 1 << LOG2_N;
  localparam int SW = DATA_W + LOG2_N;

  typedef enum logic [1:0] {IDLE, LATCH, ACCUM, OUT} state_e;

  state_e                        state_q;
  logic                          s1_q, s2_q, s3_q;
  logic                          strobe_edge;
  logic [DATA_W-1:0]             sample_q, old_q;
  logic [SW-1:0]                 sum_q, sum_d;
  logic [LOG2_N-1:0]             wr_ptr_q;
  logic [LOG2_N:0]               fill_cnt_q, fill_cnt_d;
  logic [N-1:0][DATA_W-1:0]      mem_q;
  logic [DATA_W-1:0]             avg_q;
  logic                          avg_valid_q, filled_q, overrun_q;

  assign strobe_edge = s2_q & ~s3_q;

  // old is always part of sum, so add-then-subtract at full width cannot wrap
  assign sum_d      = sum_q + SW'(sample_q) - SW'(old_q);
  assign fill_cnt_d = (fill_cnt_q == (LOG2_N+1)'(N)) ? fill_cnt_q
                                                    : fill_cnt_q + (LOG2_N+1)'(1);

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      sample_q    <= '0;
      old_q       <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      mem_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      filled_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s1_q        <= response_valid_in;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      avg_valid_q <= 1'b0;
      if (strobe_edge && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE:  if (strobe_edge) state_q <= LATCH;
        LATCH: begin
          sample_q <= adc_in;
          old_q    <= mem_q[wr_ptr_q];
          state_q  <= ACCUM;
        end
        ACCUM: begin
          sum_q           <= sum_d;
          mem_q[wr_ptr_q] <= sample_q;
          wr_ptr_q        <= wr_ptr_q + LOG2_N'(1);
          fill_cnt_q      <= fill_cnt_d;
          // result registered on entry to OUT so data, valid and filled align
          avg_q           <= sum_d[SW-1:LOG2_N];
          avg_valid_q     <= 1'b1;
          if (fill_cnt_d == (LOG2_N+1)'(N)) filled_q <= 1'b1;
          state_q         <= OUT;
        end
        OUT:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avg_out   = avg_q;
  assign avg_valid = avg_valid_q;
  assign filled    = filled_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_adc_moving_averager.sv
// Self-checking bench: vector table for the ramp/wrap cases, a queue-based window
// model for random streams, and hand-written overrun/hold/reset sequences.
module tb_adc_moving_averager;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        strobe = 1'b0;
  logic [11:0] adc = '0;
  logic [11:0] avg_out;
  logic        avg_valid, filled, overrun;

  adc_moving_averager #(.DATA_W(12), .LOG2_N(4)) dut (
    .MAX10_CLK1_50(clk), .reset(reset), .response_valid_in(strobe), .adc_in(adc),
    .avg_out(avg_out), .avg_valid(avg_valid), .filled(filled), .overrun(overrun));

  always #10 clk = ~clk;

  typedef struct { logic [11:0] v; logic [11:0] exp; logic expf; } vec_t;
  vec_t tbl[24];

  int cmp = 0, bad = 0;
  int pulses = 0;
  logic [11:0] last_avg;
  logic        last_filled;
  int win[$];
  int nacc = 0;

  always @(negedge clk) if (avg_valid) begin
    pulses++; last_avg = avg_out; last_filled = filled;
  end

  task automatic chk(input string name, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_avg();
    int s = 0;
    foreach (win[i]) s += win[i];
    return s / 16;
  endfunction

  task automatic model_push(input int v);
    win.push_back(v);
    if (win.size() > 16) void'(win.pop_front());
    nacc++;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_avg", avg_out, 0); chk("rst_flags", {avg_valid, filled, overrun}, 0);
    reset = 1'b0;
    win.delete(); nacc = 0;
  endtask

  // One strobe of `width` clocks inside a `period`-clock slot; checks against the model.
  task automatic send(input logic [11:0] v, input int width, input int period);
    int p0 = pulses;
    model_push(v);
    adc = v; strobe = 1'b1;
    repeat (width) @(negedge clk);
    strobe = 1'b0;
    repeat (period - width) @(negedge clk);
    chk("pulse_count", pulses - p0, 1);
    chk("model_avg", last_avg, model_avg());
    chk("model_filled", last_filled, (nacc >= 16) ? 1 : 0);
  endtask

  initial begin
    int lat, p0;
    for (int i = 0; i < 16; i++) tbl[i] = '{12'h100, 12'(16 * (i + 1)), (i == 15)};
    for (int j = 0; j < 8; j++)  tbl[16 + j] = '{12'h200, 12'(256 + 16 * (j + 1)), 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_avg", avg_out, 0); chk("reset_flags", {avg_valid, filled, overrun}, 0);
    reset = 1'b0;

    // ramp to 0x100 then step to 0x200 across the pointer wrap
    for (int i = 0; i < 24; i++) begin
      send(tbl[i].v, 2, 50);
      chk($sformatf("tbl_avg[%0d]", i), last_avg, tbl[i].exp);
      chk($sformatf("tbl_filled[%0d]", i), last_filled, tbl[i].expf);
    end

    // sim-model style counting stream
    do_reset();
    for (int c = 0; c < 32; c++) begin
      send(12'h8C0 | 12'(c), 1, 12);
      if (c == 15) chk("count_0_15", last_avg, 12'h8C7);
    end

    for (int i = 0; i < 40; i++) begin
      int w = $urandom_range(1, 8);
      send(12'($urandom_range(0, 4095)), w, w + 10);
    end

    // full scale then zero
    for (int i = 0; i < 16; i++) send(12'hFFF, 1, 12);
    chk("full_scale", last_avg, 12'hFFF);
    for (int i = 0; i < 16; i++) send(12'h000, 1, 12);
    chk("zero", last_avg, 0);

    // second edge two cycles after the first: dropped, overrun set
    chk("overrun_pre", overrun, 0);
    p0 = pulses; lat = -1;
    model_push(12'h3A0);
    adc = 12'h3A0; strobe = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      strobe = (i == 2);
      if (avg_valid && lat < 0) lat = i;
    end
    chk("latency", lat, 5);
    chk("overlap_pulses", pulses - p0, 1);
    chk("overlap_avg", last_avg, model_avg());
    chk("overrun_set", overrun, 1);

    send(12'h5A5, 100, 120);
    chk("overrun_sticky", overrun, 1);

    // reset during ACCUM after 5 samples
    do_reset();
    for (int i = 0; i < 5; i++) send(12'h100, 2, 20);
    adc = 12'h100; strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1; #1;
    chk("midrst_avg", avg_out, 0); chk("midrst_flags", {avg_valid, filled, overrun}, 0);
    @(negedge clk); reset = 1'b0;
    win.delete(); nacc = 0;
    for (int i = 0; i < 16; i++) begin
      send(tbl[i].v, 2, 50);
      chk($sformatf("replay_avg[%0d]", i), last_avg, tbl[i].exp);
      chk($sformatf("replay_filled[%0d]", i), last_filled, tbl[i].expf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
